// File: rtl/sprite_mover_if.sv
// Bundles the keyboard/control inputs and sprite state outputs of sprite_mover.
// The master side drives keys and control; the slave side (the mover) reports position.
interface sprite_mover_if #(
  parameter int W  = 10,
  parameter int SW = 3
);
  logic [7:0]    keycode0;
  logic [7:0]    keycode1;
  logic          freeze;
  logic          respawn;
  logic [W-1:0]  PosX;
  logic [W-1:0]  PosY;
  logic [W-1:0]  Size;
  logic [SW-1:0] Speed;
  logic          moving;
  logic          hit_x;
  logic          hit_y;

  modport master (
    output keycode0, keycode1, freeze, respawn,
    input  PosX, PosY, Size, Speed, moving, hit_x, hit_y
  );

  modport slave (
    input  keycode0, keycode1, freeze, respawn,
    output PosX, PosY, Size, Speed, moving, hit_x, hit_y
  );
endinterface

// File: rtl/sprite_mover.sv
// Keyboard-driven sprite position engine: two-slot key decode, per-direction speed
// ramp, and clamping of the sprite centre inside the playfield with wall-contact flags.
module sprite_mover #(
  parameter int         W            = 10,
  parameter int         X_MIN        = 0,
  parameter int         X_MAX        = 639,
  parameter int         Y_MIN        = 0,
  parameter int         Y_MAX        = 479,
  parameter int         X_START      = 320,
  parameter int         Y_START      = 240,
  parameter int         SIZE         = 4,
  parameter int         MAX_SPEED    = 4,
  parameter int         ACCEL_FRAMES = 8,
  parameter logic [7:0] KEY_LEFT     = 8'd80,
  parameter logic [7:0] KEY_RIGHT    = 8'd79,
  parameter logic [7:0] KEY_DOWN     = 8'd81,
  parameter logic [7:0] KEY_UP       = 8'd82,
  localparam int        SW           = $clog2(MAX_SPEED + 1)
) (
  input  logic           Reset,
  input  logic           frame_clk,
  sprite_mover_if.slave  bus
);

  localparam int CW = $clog2(ACCEL_FRAMES + 1);

  localparam logic signed [W+1:0] X_LO = (W+2)'(X_MIN + SIZE);
  localparam logic signed [W+1:0] X_HI = (W+2)'(X_MAX - SIZE);
  localparam logic signed [W+1:0] Y_LO = (W+2)'(Y_MIN + SIZE);
  localparam logic signed [W+1:0] Y_HI = (W+2)'(Y_MAX - SIZE);

  typedef enum logic [1:0] {IDLE, RAMP, CRUISE} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   speed, speed_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      dir_q;
  logic [W-1:0]    pos_x, pos_y;
  logic            hit_x_q, hit_y_q;

  logic            key_l, key_r, key_d, key_u;
  logic signed [1:0] dx, dy;
  logic [3:0]      dir;
  logic signed [W+1:0] nx, ny, cx, cy;
  logic            clamp_x, clamp_y;

  // A key counts once even if it appears in both slots; opposing keys cancel.
  always_comb begin
    key_l = (bus.keycode0 == KEY_LEFT)  || (bus.keycode1 == KEY_LEFT);
    key_r = (bus.keycode0 == KEY_RIGHT) || (bus.keycode1 == KEY_RIGHT);
    key_d = (bus.keycode0 == KEY_DOWN)  || (bus.keycode1 == KEY_DOWN);
    key_u = (bus.keycode0 == KEY_UP)    || (bus.keycode1 == KEY_UP);
    dx = 2'sd0;
    dy = 2'sd0;
    if (key_r && !key_l) dx = 2'sd1;
    if (key_l && !key_r) dx = -2'sd1;
    if (key_d && !key_u) dy = 2'sd1;
    if (key_u && !key_d) dy = -2'sd1;
    dir = {dx, dy};
  end

  always_comb begin
    state_n = state;
    speed_n = speed;
    cnt_n   = cnt;
    if (bus.respawn || bus.freeze || dir == 4'd0) begin
      state_n = IDLE;
      speed_n = '0;
      cnt_n   = '0;
    end else if (state == IDLE || dir != dir_q) begin
      state_n = (MAX_SPEED == 1) ? CRUISE : RAMP;
      speed_n = SW'(1);
      cnt_n   = CW'(1);
    end else if (state == RAMP) begin
      if (cnt == CW'(ACCEL_FRAMES)) begin
        speed_n = speed + SW'(1);
        cnt_n   = CW'(1);
        if (speed + SW'(1) == SW'(MAX_SPEED)) state_n = CRUISE;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end else begin
      state_n = CRUISE;
      speed_n = SW'(MAX_SPEED);
    end
  end

  // Widened signed arithmetic keeps steps past either edge from wrapping.
  always_comb begin
    nx = $signed({2'b00, pos_x}) + $signed({{W{dx[1]}}, dx}) * $signed({{(W+2-SW){1'b0}}, speed_n});
    ny = $signed({2'b00, pos_y}) + $signed({{W{dy[1]}}, dy}) * $signed({{(W+2-SW){1'b0}}, speed_n});
    cx = nx;
    cy = ny;
    clamp_x = 1'b0;
    clamp_y = 1'b0;
    if (nx < X_LO) begin cx = X_LO; clamp_x = 1'b1; end
    if (nx > X_HI) begin cx = X_HI; clamp_x = 1'b1; end
    if (ny < Y_LO) begin cy = Y_LO; clamp_y = 1'b1; end
    if (ny > Y_HI) begin cy = Y_HI; clamp_y = 1'b1; end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      speed   <= '0;
      cnt     <= '0;
      dir_q   <= '0;
      pos_x   <= W'(X_START);
      pos_y   <= W'(Y_START);
      hit_x_q <= 1'b0;
      hit_y_q <= 1'b0;
    end else begin
      state <= state_n;
      speed <= speed_n;
      cnt   <= cnt_n;
      if (bus.respawn) begin
        dir_q   <= '0;
        pos_x   <= W'(X_START);
        pos_y   <= W'(Y_START);
        hit_x_q <= 1'b0;
        hit_y_q <= 1'b0;
      end else if (bus.freeze) begin
        dir_q   <= dir;
        hit_x_q <= 1'b0;
        hit_y_q <= 1'b0;
      end else begin
        dir_q   <= dir;
        pos_x   <= cx[W-1:0];
        pos_y   <= cy[W-1:0];
        hit_x_q <= clamp_x;
        hit_y_q <= clamp_y;
      end
    end
  end

  assign bus.PosX   = pos_x;
  assign bus.PosY   = pos_y;
  assign bus.Size   = W'(SIZE);
  assign bus.Speed  = speed;
  assign bus.moving = (state != IDLE);
  assign bus.hit_x  = hit_x_q;
  assign bus.hit_y  = hit_y_q;

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Keyboard-driven sprite position engine for the VGA playfield, generalising the single-key ball mover. On every `frame_clk` edge it decodes two keycode slots into a diagonal-capable direction and ramps speed while a direction is held. It clamps the sprite centre inside parametrised screen bounds and reports wall contact. Its outputs feed the colour mapper and the collision logic directly.

## Interface
- `W`, 10, coordinate width in bits.
- `X_MIN`/`X_MAX`, 0/639, horizontal screen bounds.
- `Y_MIN`/`Y_MAX`, 0/479, vertical screen bounds.
- `X_START`/`Y_START`, 320/240, centre position loaded on reset and respawn.
- `SIZE`, 4, sprite half-size, constant.
- `MAX_SPEED`, 4, top speed in pixels per frame; must be ≥1.
- `ACCEL_FRAMES`, 8, frames spent at each speed level before incrementing; must be ≥1.
- `KEY_LEFT`/`KEY_RIGHT`/`KEY_DOWN`/`KEY_UP`, 80/79/81/82, USB HID keycodes.
- Local: `SW = $clog2(MAX_SPEED+1)`.

Ports:
- `Reset`  in  1  reset, asynchronous, active-high.
- `frame_clk`  in  1  clock, one edge per video frame.
- `keycode0`, `keycode1`  in  8 each  currently pressed keys; 0 means none.
- `freeze`  in  1  hold position; speed forced to 0.
- `respawn`  in  1  synchronous return to start.
- `PosX`, `PosY`  out  W each  sprite centre.
- `Size`  out  W  constant `SIZE`.
- `Speed`  out  SW  current speed.
- `moving`  out  1  high when state ≠ IDLE.
- `hit_x`, `hit_y`  out  1 each  the position on this axis was clamped this frame.

## Operation
- **Direction decode.**
  - `dx = R − L`, where R/L are true if either slot equals the key. The same key in both slots counts once.
  - `dy = D − U` on the same rule.
  - Opposite keys cancel to 0 on that axis. The direction vector is `dir = {dx,dy}`, and `dir_q` holds its registered previous value.
- **States: IDLE, RAMP, CRUISE.**
  - Any state with `dir==0` or `freeze`: go to IDLE, speed 0, counter 0.
  - IDLE with `dir≠0`: go to RAMP with speed 1 and counter 1. If `MAX_SPEED==1`, go to CRUISE instead.
  - RAMP with `dir==dir_q`:
    - If counter == `ACCEL_FRAMES`: speed+1 and counter 1. If the new speed equals `MAX_SPEED`, go to CRUISE.
    - Otherwise: counter+1.
  - RAMP or CRUISE with `dir≠dir_q` and `dir≠0`: go to RAMP with speed 1 and counter 1. Any direction change restarts the ramp.
  - CRUISE with `dir==dir_q`: stay, speed `MAX_SPEED`.
- **Position.** On the same edge, using the newly computed speed `s`: `nx = PosX + dx·s`, `ny = PosY + dy·s`.
  - Compute in W+2-bit signed to prevent wrap-around below 0 or above 2^W−1.
- **Clamping.**
  - Legal X range is `[X_MIN+SIZE, X_MAX−SIZE]`, and Y likewise.
  - An out-of-range result is set to the violated limit, and the axis `hit_*` goes to 1 for that frame.
  - Pushing against a wall while already at the limit also asserts `hit_*` every frame.
  - There is no bounce, and speed is unaffected by clamping.
- **Priority:** `Reset` > `respawn` > `freeze` > keys.
- **`respawn`:** `PosX=X_START`, `PosY=Y_START`, IDLE, speed 0, `dir_q` 0, hits 0.
- **`freeze`:** position held, hits 0, state IDLE, `dir_q` updated from the keys.

## Timing
- **Reset values:** `PosX=X_START`, `PosY=Y_START`, `Speed=0`, `moving=0`, `hit_x=hit_y=0`, state IDLE, counter 0, `dir_q=0`. `Size=SIZE` always.
- **Latency:** a key sampled at edge k moves the sprite at edge k. Outputs are registered and valid after edge k. There is no extra frame of motion delay.
- **Speed profile:** while one direction is held, speed is s for exactly `ACCEL_FRAMES` frames, then s+1, until `MAX_SPEED`.
- **Reset mid-motion:** immediate reset values; the ramp restarts from speed 1 on the next key frame.
- **Key release:** speed 0 on the same edge, with no coasting.

## Test plan
- **Reset:** assert `Reset` between edges → `PosX=320`, `PosY=240`, `Speed=0`, `moving=0`, hits 0, with no clock edge needed.
- **Ramp:** `keycode0=79` held for 30 frames (defaults) → speed 1 for frames 1–8, 2 for frames 9–16, 3 for frames 17–24, 4 from frame 25. `PosX=368` after frame 24, 392 after frame 30, `PosY=240`.
- **Wall clamp:** hold right from reset → `PosX=632` after frame 90; frame 91 gives `PosX=635` and `hit_x=1`, and `hit_x` stays 1 with `PosX=635` while held. Release → `hit_x=0`, `Speed=0`.
- **Diagonal and cancel:**
  - `keycode0=79`, `keycode1=82` → each frame x+s, y−s.
  - `keycode0=80`, `keycode1=79` → `dx=0`, `Speed=0`, IDLE, no motion.
  - Switching 79→80 at speed 3 → next frame speed 1, x decreases.
- **Lower-bound wrap:** `Y_MIN=0`, hold up until `PosY=4` → further frames keep `PosY=4` and `hit_y=1`, with no wrap to 1023.
- **Freeze and respawn:**
  - `freeze=1` with right held → `PosX` constant, `Speed=0`, `moving=0`.
  - `respawn` and `freeze` together → position (320,240) on that edge.
  - Release `freeze` with the key held → speed 1 on the next frame.
